// File: rtl/shift_pkg.sv
// Shared definitions for the shift issue stage and the shift unit behind it.
//   SH_N        : default datapath width used by shift_req_t
//   SH_*        : 2-bit shift-unit opcodes
//   F3_*        : RISC-V funct3 values for the shift group
//   shift_req_t : operation record handed to the shift unit
//   decode_ope  : funct3/bit30 -> opcode decode
package shift_pkg;

   localparam int SH_N = 32;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_INV = 2'b11;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   typedef struct packed {
      logic [SH_N-1:0] a;
      logic [SH_N-1:0] b;
      logic [1:0]      ope;
      logic [4:0]      rd;
      logic            illegal;
   } shift_req_t;

   // SLL only exists with bit30 clear; SRL/SRA share funct3 and split on bit30.
   function automatic logic [1:0] decode_ope(input logic [2:0] f3, input logic b5);
      logic [1:0] ope;
      ope = SH_INV;
      if (f3 == F3_SLL && !b5) ope = SH_SLL;
      else if (f3 == F3_SRX)   ope = b5 ? SH_SRA : SH_SRL;
      return ope;
   endfunction

endpackage

// File: rtl/shift_issue_if.sv
// Handshake and operand bundle between decode, the issue stage and the shift unit.
//   upstream  : valid_i/ready_o, funct3_i, funct7b5_i, is_imm_i, rs1_i, rs2_i, imm_i, rd_i
//   downstream: valid_o/ready_i, a_o, b_o, ope_o, rd_o, illegal_o
// slave is the issue stage's view, master the view of whatever surrounds it.
interface shift_issue_if #(parameter int N = 32);
   logic         valid_i;
   logic         ready_o;
   logic [2:0]   funct3_i;
   logic         funct7b5_i;
   logic         is_imm_i;
   logic [N-1:0] rs1_i;
   logic [N-1:0] rs2_i;
   logic [N-1:0] imm_i;
   logic [4:0]   rd_i;
   logic         valid_o;
   logic         ready_i;
   logic [N-1:0] a_o;
   logic [N-1:0] b_o;
   logic [1:0]   ope_o;
   logic [4:0]   rd_o;
   logic         illegal_o;

   modport slave (
      input  valid_i, funct3_i, funct7b5_i, is_imm_i, rs1_i, rs2_i, imm_i, rd_i, ready_i,
      output ready_o, valid_o, a_o, b_o, ope_o, rd_o, illegal_o
   );

   modport master (
      output valid_i, funct3_i, funct7b5_i, is_imm_i, rs1_i, rs2_i, imm_i, rd_i, ready_i,
      input  ready_o, valid_o, a_o, b_o, ope_o, rd_o, illegal_o
   );
endinterface

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer over a W-bit payload.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : synchronous clear, beats accept and emit
//   valid_i/ready_o    : upstream handshake, data_i payload
//   valid_o/ready_i    : downstream handshake, data_o payload (main entry)
// ready_o is a flop, so there is no combinational path from ready_i back upstream.
module skid_buf #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         main_vld_q, main_vld_d;
   logic         skid_vld_q, skid_vld_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         rdy_q;
   logic         acc, emit;

   assign acc  = valid_i && rdy_q;
   assign emit = main_vld_q && ready_i;

   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (emit) begin
         // An accept cannot coincide with a full skid: ready is low then.
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (acc) begin
            main_d     = data_i;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (acc) begin
         if (!main_vld_q) begin
            main_d     = data_i;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = data_i;
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
         rdy_q      <= 1'b1;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         rdy_q      <= !skid_vld_d;
      end
   end

   assign ready_o = rdy_q;
   assign valid_o = main_vld_q;
   assign data_o  = main_q;

endmodule

// File: rtl/shift_issue.sv
// Execute-stage issue register in front of the shift unit.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : synchronous pipeline flush
//   bus           : decode-side request and shift-unit-side operation (slave view)
// Decodes funct3/bit30 to the shift opcode, picks and masks the shift amount,
// then queues the result through a two-entry skid buffer.
module shift_issue
   import shift_pkg::*;
#(
   parameter int N = SH_N
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           flush_i,
   shift_issue_if.slave   bus
);

   localparam int SHW = $clog2(N);

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [1:0]   ope;
      logic [4:0]   rd;
      logic         illegal;
   } req_t;

   localparam int W = $bits(req_t);

   req_t dec, head;

   // Only the low SHW bits of the amount survive, giving RV-legal shifts.
   always_comb begin
      dec         = '0;
      dec.a       = bus.rs1_i;
      dec.b       = {{(N-SHW){1'b0}}, (bus.is_imm_i ? bus.imm_i[SHW-1:0] : bus.rs2_i[SHW-1:0])};
      dec.ope     = decode_ope(bus.funct3_i, bus.funct7b5_i);
      dec.rd      = bus.rd_i;
      dec.illegal = (dec.ope == SH_INV);
   end

   skid_buf #(.W(W)) u_skid (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_i (bus.valid_i),
      .ready_o (bus.ready_o),
      .data_i  (dec),
      .valid_o (bus.valid_o),
      .ready_i (bus.ready_i),
      .data_o  (head)
   );

   assign bus.a_o       = head.a;
   assign bus.b_o       = head.b;
   assign bus.ope_o     = head.ope;
   assign bus.rd_o      = head.rd;
   assign bus.illegal_o = head.illegal;

endmodule
